alu_arbiter: RTL

Shares one instance of the RV32I ALU between two requesters, e.g. the main execute path and an auxiliary address/compare unit, so the second source needs no duplicate ALU. Each requester presents operands and a 4-bit ALU op under a valid/ready handshake. A round-robin arbiter picks one requester per cycle and registers its operands. The single result leaves through a registered valid/ready output tagged with the winning requester's id.

---
 rtl/alu_arbiter_pkg.sv | 23 ++
 rtl/alu_arbiter_alu.sv | 36 +++
 rtl/alu_arbiter.sv | 104 ++++++++++
 3 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared widths, ALU op codes and result-slot state for the ALU arbiter.
package alu_arbiter_pkg;

  localparam int DATA_W = 32;
  localparam int OP_W   = 4;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SLTU = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// RV32I integer ALU, purely combinational.
// Shifts use b[4:0]; add/sub wrap with no flags.
module alu
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_W = alu_arbiter_pkg::DATA_W,
  parameter int OP_W   = alu_arbiter_pkg::OP_W
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [OP_W-1:0]   op,
  output logic [DATA_W-1:0] y
);

  logic [4:0] sh;

  assign sh = b[4:0];

  always_comb begin
    y = '0;
    unique case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_SLT:  y = {{(DATA_W-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: y = {{(DATA_W-1){1'b0}}, a < b};
      OP_SLL:  y = a << sh;
      OP_SRL:  y = a >> sh;
      OP_SRA:  y = $unsigned($signed(a) >>> sh);
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin share of one ALU between two requesters,
// with a single registered, id-tagged result slot.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_W = alu_arbiter_pkg::DATA_W,
  parameter int OP_W   = alu_arbiter_pkg::OP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid_i,
  output logic              req0_ready_o,
  input  logic [DATA_W-1:0] req0_a_i,
  input  logic [DATA_W-1:0] req0_b_i,
  input  logic [OP_W-1:0]   req0_op_i,
  input  logic              req1_valid_i,
  output logic              req1_ready_o,
  input  logic [DATA_W-1:0] req1_a_i,
  input  logic [DATA_W-1:0] req1_b_i,
  input  logic [OP_W-1:0]   req1_op_i,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic              res_id_o,
  output logic [DATA_W-1:0] res_o
);

  state_t            state;
  state_t            state_nx;
  logic              last_grant;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [OP_W-1:0]   op_q;
  logic              id_q;
  logic              free;
  logic              grant0;
  logic              grant1;
  logic              acc0;
  logic              acc1;

  assign res_valid_o = (state == FULL);
  assign res_id_o    = id_q;
  assign free        = !res_valid_o || res_ready_i;

  // Under contention the requester that did not win last time goes.
  assign grant0 = req0_valid_i && (!req1_valid_i || last_grant);
  assign grant1 = req1_valid_i && (!req0_valid_i || !last_grant);

  // Gating with rst keeps an in-flight op from looking accepted.
  assign req0_ready_o = rst && free && grant0;
  assign req1_ready_o = rst && free && grant1;

  assign acc0 = req0_valid_i && req0_ready_o;
  assign acc1 = req1_valid_i && req1_ready_o;

  always_comb begin
    state_nx = state;
    if (acc0 || acc1) begin
      state_nx = FULL;
    end else if (res_valid_o && res_ready_i) begin
      state_nx = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= EMPTY;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      id_q       <= 1'b0;
      last_grant <= 1'b1;
    end else if (acc0) begin
      a_q        <= req0_a_i;
      b_q        <= req0_b_i;
      op_q       <= req0_op_i;
      id_q       <= 1'b0;
      last_grant <= 1'b0;
    end else if (acc1) begin
      a_q        <= req1_a_i;
      b_q        <= req1_b_i;
      op_q       <= req1_op_i;
      id_q       <= 1'b1;
      last_grant <= 1'b1;
    end
  end

  alu #(
    .DATA_W (DATA_W),
    .OP_W   (OP_W)
  ) u_alu0 (
    .a  (a_q),
    .b  (b_q),
    .op (op_q),
    .y  (res_o)
  );

endmodule
